ddram_rom_arbiter: RTL and testbench

//  Shares the single DDR3 (DDRAM_*) Avalon port between two requesters:
//   - the ROM download writer (16-bit words from hps_io);
//   - the cartridge ROM read port (64-bit lines to Virtual_Toplevel).

---
 rtl/ddram_rom_arbiter.sv | 136 +++++++++++++
 tb/tb_ddram_rom_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_rom_arbiter.sv
// ddram_rom_arbiter: shares one DDRAM Avalon port between ROM download writes and cached cartridge ROM line reads
module ddram_rom_arbiter #(
  parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
  parameter bit          CACHE_EN  = 1'b1
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic [24:0] WR_ADDR,
  input  logic [15:0] WR_DATA,
  input  logic        WR_REQ,
  output logic        WR_ACK,
  input  logic [21:0] RD_ADDR,
  input  logic        RD_REQ,
  output logic [63:0] RD_DATA,
  output logic        RD_ACK,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} state_t;
  state_t state_q, state_d;
  logic wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, rd_q, rd_d, we_q, we_d;
  logic valid_q, valid_d, rd_out_q, rd_out_d;
  logic [63:0] rd_data_q, rd_data_d, din_q, din_d, line_q, line_d;
  logic [28:0] addr_q, addr_d;
  logic [7:0] be_q, be_d;
  logic [21:0] tag_q, tag_d;
  logic wr_pend, rd_pend, hit, unused_ok;
  assign wr_pend = WR_REQ != wr_ack_q;
  assign rd_pend = RD_REQ != rd_ack_q;
  assign hit = CACHE_EN && valid_q && tag_q == RD_ADDR;
  assign unused_ok = WR_ADDR[0];
  assign WR_ACK = wr_ack_q;
  assign RD_ACK = rd_ack_q;
  assign RD_DATA = rd_data_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR = addr_q;
  assign DDRAM_RD = rd_q;
  assign DDRAM_DIN = din_q;
  assign DDRAM_BE = be_q;
  assign DDRAM_WE = we_q;
  always_comb begin
    state_d = state_q;
    wr_ack_d = wr_ack_q;
    rd_ack_d = rd_ack_q;
    rd_d = rd_q;
    we_d = we_q;
    valid_d = valid_q;
    rd_data_d = rd_data_q;
    din_d = din_q;
    line_d = line_q;
    addr_d = addr_q;
    be_d = be_q;
    tag_d = tag_q;
    rd_out_d = DDRAM_DOUT_READY ? 1'b0 : (state_q == RD_CMD && !DDRAM_BUSY) ? 1'b1 : rd_out_q;
    case (state_q)
      IDLE: begin
        if (wr_pend) begin
          if (!rd_out_q) begin
            state_d = WR_CMD;
            we_d = 1'b1;
            addr_d = BASE_ADDR + 29'(WR_ADDR[24:3]);
            din_d = {4{WR_DATA}};
            be_d = 8'b11 << {WR_ADDR[2:1], 1'b0};
          end
        end else if (rd_pend && hit) begin
          rd_data_d = line_q;
          rd_ack_d = RD_REQ;
        end else if (rd_pend && !rd_out_q) begin
          state_d = RD_CMD;
          rd_d = 1'b1;
          addr_d = BASE_ADDR + 29'(RD_ADDR);
        end
      end
      WR_CMD: begin
        if (!DDRAM_BUSY) begin
          state_d = IDLE;
          we_d = 1'b0;
          wr_ack_d = WR_REQ;
          valid_d = WR_ADDR[24:3] == tag_q ? 1'b0 : valid_q;
        end
      end
      RD_CMD: begin
        if (!DDRAM_BUSY) begin
          state_d = RD_WAIT;
          rd_d = 1'b0;
          tag_d = RD_ADDR;
          valid_d = 1'b0;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          state_d = IDLE;
          rd_data_d = DDRAM_DOUT;
          line_d = DDRAM_DOUT;
          valid_d = CACHE_EN;
          rd_ack_d = RD_REQ;
        end
      end
    endcase
  end
  always_ff @(posedge MCLK) begin
    rd_out_q <= rd_out_d;
    line_q <= line_d;
    tag_q <= tag_d;
    if (!RESET_N) begin
      state_q <= IDLE;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_q <= 1'b0;
      we_q <= 1'b0;
      valid_q <= 1'b0;
      rd_data_q <= '0;
      din_q <= '0;
      addr_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      rd_q <= rd_d;
      we_q <= we_d;
      valid_q <= valid_d;
      rd_data_q <= rd_data_d;
      din_q <= din_d;
      addr_q <= addr_d;
      be_q <= be_d;
    end
  end
endmodule

// File: tb/tb_ddram_rom_arbiter.sv
// tb_ddram_rom_arbiter: directed bench with a DDRAM responder and a word-level ROM model
module tb_ddram_rom_arbiter;
  localparam logic [28:0] BASE = 29'h0600_0000;
  logic MCLK = 0, RESET_N = 0;
  logic [24:0] WR_ADDR = '0;
  logic [15:0] WR_DATA = '0;
  logic WR_REQ = 0, WR_ACK;
  logic [21:0] RD_ADDR = '0;
  logic RD_REQ = 0, RD_ACK;
  logic [63:0] RD_DATA;
  logic DDRAM_BUSY = 0;
  logic [7:0] DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic DDRAM_DOUT_READY = 0, DDRAM_RD, DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0] DDRAM_BE;
  ddram_rom_arbiter dut (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_REQ(WR_REQ), .WR_ACK(WR_ACK),
    .RD_ADDR(RD_ADDR), .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_ACK(RD_ACK),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );
  always #5 MCLK = ~MCLK;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, rd_cmds = 0, we_cycles = 0, cmd_cycles = 0;
  int busy_cfg = 0, busy_left = 0, rd_lat = 5, last_wr_t = 0, last_rd_t = 0, ln;
  bit active = 0;
  logic prev_rd_ack = 0, prev_wr_ack = 0;
  logic [28:0] cap_wr_addr = '0, cap_rd_addr = '0;
  logic [7:0] cap_be = '0;
  logic [63:0] cap_din = '0, m;
  logic [63:0] mem[int];
  logic [15:0] ref_w[int];
  int q_t[$];
  logic [63:0] q_d[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] model_line(input logic [21:0] l);
    logic [63:0] v = '0;
    for (int k = 0; k < 4; k++)
      if (ref_w.exists(int'(l) * 4 + k)) v[16*k +: 16] = ref_w[int'(l) * 4 + k];
    return v;
  endfunction
  function automatic logic [7:0] be_of(input logic [1:0] k);
    logic [7:0] b = '0;
    b[2*k +: 2] = 2'b11;
    return b;
  endfunction
  task automatic preload(input int line, input logic [63:0] v);
    mem[line] = v;
    for (int k = 0; k < 4; k++) ref_w[line * 4 + k] = v[16*k +: 16];
  endtask
  always begin
    @(posedge MCLK);
    #1;
    cyc++;
    chk("burstcnt", DDRAM_BURSTCNT, 8'd1);
    chk("rd_we_exclusive", DDRAM_RD & DDRAM_WE, 0);
    if (q_t.size() > 0) chk("cmd_while_read_outstanding", DDRAM_RD | DDRAM_WE, 0);
    if (DDRAM_WE) begin
      chk("we_addr", DDRAM_ADDR, 29'(BASE + 29'(WR_ADDR[24:3])));
      chk("we_din", DDRAM_DIN, {4{WR_DATA}});
      chk("we_be", DDRAM_BE, be_of(WR_ADDR[2:1]));
    end
    if (DDRAM_RD) chk("rd_addr", DDRAM_ADDR, 29'(BASE + 29'(RD_ADDR)));
    if (RESET_N && RD_ACK !== prev_rd_ack) begin
      chk("rd_ack_matches_req", RD_ACK, RD_REQ);
      chk("rd_data_model", RD_DATA, model_line(RD_ADDR));
    end
    if (RESET_N && WR_ACK !== prev_wr_ack) chk("wr_ack_matches_req", WR_ACK, WR_REQ);
    prev_rd_ack = RD_ACK;
    prev_wr_ack = WR_ACK;
    if (DDRAM_WE) we_cycles++;
    if (DDRAM_WE || DDRAM_RD) cmd_cycles++;
    DDRAM_DOUT_READY = 0;
    foreach (q_t[i]) q_t[i]--;
    if (q_t.size() > 0 && q_t[0] <= 0) begin
      DDRAM_DOUT = q_d[0];
      DDRAM_DOUT_READY = 1;
      void'(q_t.pop_front());
      void'(q_d.pop_front());
    end
    if (DDRAM_RD || DDRAM_WE) begin
      if (!active) begin
        active = 1;
        busy_left = busy_cfg;
      end
      if (busy_left > 0) begin
        DDRAM_BUSY = 1;
        busy_left--;
      end else begin
        DDRAM_BUSY = 0;
        active = 0;
        ln = int'(29'(DDRAM_ADDR - BASE));
        if (DDRAM_WE) begin
          m = mem.exists(ln) ? mem[ln] : '0;
          for (int b = 0; b < 8; b++) if (DDRAM_BE[b]) m[8*b +: 8] = DDRAM_DIN[8*b +: 8];
          mem[ln] = m;
          last_wr_t = cyc;
          cap_wr_addr = DDRAM_ADDR;
          cap_be = DDRAM_BE;
          cap_din = DDRAM_DIN;
        end else begin
          rd_cmds++;
          last_rd_t = cyc;
          cap_rd_addr = DDRAM_ADDR;
          q_t.push_back(rd_lat);
          q_d.push_back(mem.exists(ln) ? mem[ln] : '0);
        end
      end
    end else begin
      DDRAM_BUSY = 0;
      active = 0;
    end
  end
  task automatic wait_wr();
    for (int i = 0; i < 300 && WR_ACK !== WR_REQ; i++) @(negedge MCLK);
    chk("wr_ack_wait", WR_ACK, WR_REQ);
  endtask
  task automatic wait_rd();
    for (int i = 0; i < 300 && RD_ACK !== RD_REQ; i++) @(negedge MCLK);
    chk("rd_ack_wait", RD_ACK, RD_REQ);
  endtask
  task automatic do_wr(input logic [24:0] a, input logic [15:0] d);
    @(negedge MCLK);
    WR_ADDR = a;
    WR_DATA = d;
    ref_w[int'(a >> 1)] = d;
    WR_REQ = ~WR_REQ;
    wait_wr();
  endtask
  task automatic do_rd(input logic [21:0] a);
    @(negedge MCLK);
    RD_ADDR = a;
    RD_REQ = ~RD_REQ;
    wait_rd();
  endtask
  initial begin
    int c0, r0, w0;
    repeat (3) @(negedge MCLK);
    chk("rst_wr_ack", WR_ACK, 0);
    chk("rst_rd_ack", RD_ACK, 0);
    chk("rst_rd", DDRAM_RD, 0);
    chk("rst_we", DDRAM_WE, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_burstcnt", DDRAM_BURSTCNT, 8'd1);
    RESET_N = 1;
    c0 = cmd_cycles;
    repeat (20) @(negedge MCLK);
    chk("idle_no_cmd", cmd_cycles - c0, 0);
    busy_cfg = 3;
    w0 = we_cycles;
    do_wr(25'h000006, 16'hA55A);
    chk("wr_we_cycles", we_cycles - w0, 4);
    chk("wr_addr", cap_wr_addr, 29'h0600_0000);
    chk("wr_be", cap_be, 8'hC0);
    chk("wr_din", cap_din, 64'hA55A_A55A_A55A_A55A);
    chk("wr_ack_set", WR_ACK, 1);
    busy_cfg = 0;
    rd_lat = 5;
    preload(32'h10, 64'h0123_4567_89AB_CDEF);
    r0 = rd_cmds;
    do_rd(22'h10);
    chk("miss_rd_cmds", rd_cmds - r0, 1);
    chk("miss_rd_addr", cap_rd_addr, 29'h0600_0010);
    chk("miss_rd_data", RD_DATA, 64'h0123_4567_89AB_CDEF);
    chk("miss_rd_ack", RD_ACK, 1);
    @(negedge MCLK);
    RD_REQ = ~RD_REQ;
    r0 = rd_cmds;
    @(negedge MCLK);
    chk("hit_one_cycle", RD_ACK, RD_REQ);
    wait_rd();
    repeat (3) @(negedge MCLK);
    chk("hit_no_rd_cmd", rd_cmds - r0, 0);
    chk("hit_rd_data", RD_DATA, 64'h0123_4567_89AB_CDEF);
    do_wr(25'h000080, 16'hBEEF);
    busy_cfg = 2;
    r0 = rd_cmds;
    do_rd(22'h10);
    chk("inval_rd_cmds", rd_cmds - r0, 1);
    chk("inval_rd_data", RD_DATA, 64'h0123_4567_89AB_BEEF);
    busy_cfg = 1;
    preload(32'h21, 64'hFEDC_BA98_7654_3210);
    @(negedge MCLK);
    WR_ADDR = 25'h000100;
    WR_DATA = 16'h1111;
    ref_w[32'h80] = 16'h1111;
    RD_ADDR = 22'h21;
    WR_REQ = ~WR_REQ;
    RD_REQ = ~RD_REQ;
    wait_wr();
    wait_rd();
    chk("wr_before_rd", last_wr_t < last_rd_t, 1);
    chk("both_acks", {WR_ACK, RD_ACK}, {WR_REQ, RD_REQ});
    chk("both_rd_data", RD_DATA, 64'hFEDC_BA98_7654_3210);
    busy_cfg = 0;
    rd_lat = 6;
    preload(32'h30, 64'hAAAA_AAAA_AAAA_AAAA);
    preload(32'h31, 64'h5555_5555_5555_5555);
    @(negedge MCLK);
    RD_ADDR = 22'h30;
    RD_REQ = ~RD_REQ;
    for (int i = 0; i < 50 && q_t.size() == 0; i++) @(negedge MCLK);
    chk("stale_rd_accepted", q_t.size(), 1);
    @(negedge MCLK);
    RESET_N = 0;
    WR_REQ = 0;
    RD_REQ = 0;
    repeat (2) @(negedge MCLK);
    chk("mid_rst_rd_ack", RD_ACK, 0);
    chk("mid_rst_rd_data", RD_DATA, 0);
    RESET_N = 1;
    RD_ADDR = 22'h31;
    RD_REQ = 1;
    rd_lat = 3;
    r0 = rd_cmds;
    wait_rd();
    chk("post_rst_rd_cmds", rd_cmds - r0, 1);
    chk("post_rst_rd_data", RD_DATA, 64'h5555_5555_5555_5555);
    repeat (5) @(negedge MCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
